// File: rtl/linescanner_pkg.sv
// Shared types and constants for the line-scanner pixel packer.
package linescanner_pkg;

    localparam int unsigned PIXEL_W  = 8;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ENTRY_W  = WORD_W + 2;
    localparam int unsigned ERR_BIT  = 33;
    localparam int unsigned LAST_BIT = 32;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrop,
        StFlush
    } state_e;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic entry_t make_entry(input logic err, input logic last,
                                          input logic [WORD_W-1:0] data);
        entry_t e;
        e           = '0;
        e[ERR_BIT]  = err;
        e[LAST_BIT] = last;
        e[WORD_W-1:0] = data;
        return e;
    endfunction

endpackage

// File: rtl/linescanner_line_packer_if.sv
// Output word stream of the line packer: valid/ready with end-of-line and error marks.
interface linescanner_line_packer_if;
    import linescanner_pkg::*;

    logic [WORD_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              m_err;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        output m_err,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        input  m_err,
        output m_ready
    );

endinterface

// File: rtl/linescanner_sync_fifo.sv
// Single-clock first-word fall-through FIFO; a write into a full FIFO succeeds when a read
// happens in the same cycle.
module linescanner_sync_fifo #(
    parameter int unsigned Width = 34,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCnt = (AW+1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == FullCnt);
        do_rd    = rd_en_i && !empty_o;
        do_wr    = wr_en_i && (!full_o || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - (AW+1)'(1);
        end
        // Gated so the read port reads as zero whenever nothing is valid.
        rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/linescanner_line_packer.sv
// Packs lval-qualified 8-bit pixels into 32-bit words, buffers them, marks line ends and
// overflow-truncated lines, and reports each line's length.
module linescanner_line_packer
    import linescanner_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned LINE_PIXELS = 1024
) (
    input  logic                        pixel_clock,
    input  logic                        n_reset,
    input  logic                        enable,
    input  logic [PIXEL_W-1:0]          pixel_data,
    input  logic                        pixel_captured,
    linescanner_line_packer_if.master   m_if,
    output logic                        line_done,
    output logic [15:0]                 line_len,
    output logic                        len_error,
    output logic                        overflow,
    input  logic                        clr_status
);

    localparam logic [15:0] ExpLen = 16'(LINE_PIXELS);

    state_e            state_q, state_d;
    logic              lval_q;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [15:0]       pix_cnt_q, pix_cnt_d, pix_cnt_inc;
    logic [WORD_W-1:0] stage_q, stage_d;
    logic              stage_full_q, stage_full_d;
    entry_t            pend_q, pend_d;
    logic              line_done_q, line_done_d;
    logic [15:0]       line_len_q, line_len_d;
    logic              len_error_q, len_error_d;
    logic              overflow_q, overflow_d;

    logic   rise, pop, full_blk, fifo_full, fifo_empty;
    logic   push, finish, ovf_evt;
    entry_t push_entry, fall_entry, fifo_rdata;

    linescanner_sync_fifo #(
        .Width (ENTRY_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (pixel_clock),
        .rst_ni    (n_reset),
        .wr_en_i   (push),
        .wr_data_i (push_entry),
        .rd_en_i   (m_if.m_ready),
        .rd_data_o (fifo_rdata),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        asm_d        = asm_q;
        byte_idx_d   = byte_idx_q;
        pix_cnt_d    = pix_cnt_q;
        stage_d      = stage_q;
        stage_full_d = stage_full_q;
        pend_d       = pend_q;
        line_done_d  = 1'b0;
        line_len_d   = line_len_q;
        len_error_d  = 1'b0;
        push         = 1'b0;
        push_entry   = '0;
        finish       = 1'b0;
        ovf_evt      = 1'b0;

        rise        = pixel_captured && !lval_q;
        pop         = !fifo_empty && m_if.m_ready;
        full_blk    = fifo_full && !pop;
        pix_cnt_inc = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
        fall_entry  = stage_full_q ? make_entry(1'b0, 1'b1, stage_q)
                                   : make_entry(1'b0, 1'b1, asm_q);

        unique case (state_q)
            StIdle: begin
                if (rise && enable) begin
                    state_d      = StActive;
                    asm_d        = {24'h0, pixel_data};
                    byte_idx_d   = 2'd1;
                    pix_cnt_d    = 16'd1;
                    stage_full_d = 1'b0;
                end
            end
            StActive: begin
                if (pixel_captured) begin
                    pix_cnt_d = pix_cnt_inc;
                    if (stage_full_q && full_blk) begin
                        ovf_evt      = 1'b1;
                        stage_full_d = 1'b0;
                        asm_d        = '0;
                        byte_idx_d   = 2'd0;
                        state_d      = StDrop;
                    end else begin
                        if (stage_full_q) begin
                            push         = 1'b1;
                            push_entry   = make_entry(1'b0, 1'b0, stage_q);
                            stage_full_d = 1'b0;
                        end
                        asm_d[{byte_idx_q, 3'b000} +: PIXEL_W] = pixel_data;
                        if (byte_idx_q == 2'd3) begin
                            stage_d      = {pixel_data, asm_q[23:0]};
                            stage_full_d = 1'b1;
                            asm_d        = '0;
                        end
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    stage_full_d = 1'b0;
                    asm_d        = '0;
                    byte_idx_d   = 2'd0;
                    if (full_blk) begin
                        pend_d  = fall_entry;
                        state_d = StFlush;
                    end else begin
                        push       = 1'b1;
                        push_entry = fall_entry;
                        finish     = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (pixel_captured) begin
                    pix_cnt_d = pix_cnt_inc;
                    ovf_evt   = 1'b1;
                end else begin
                    pend_d  = make_entry(1'b1, 1'b1, '0);
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Any lval high here belongs to a new line that cannot be accepted.
                if (pixel_captured) begin
                    ovf_evt = 1'b1;
                end
                if (!full_blk) begin
                    push       = 1'b1;
                    push_entry = pend_q;
                    finish     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d     = StIdle;
            line_done_d = 1'b1;
            line_len_d  = pix_cnt_q;
            len_error_d = (pix_cnt_q != ExpLen);
        end

        overflow_d = (overflow_q && !clr_status) || ovf_evt;
    end

    always_ff @(posedge pixel_clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= StIdle;
            // Treat lval as already high so a line in progress at release is ignored.
            lval_q       <= 1'b1;
            asm_q        <= '0;
            byte_idx_q   <= '0;
            pix_cnt_q    <= '0;
            stage_q      <= '0;
            stage_full_q <= 1'b0;
            pend_q       <= '0;
            line_done_q  <= 1'b0;
            line_len_q   <= '0;
            len_error_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lval_q       <= pixel_captured;
            asm_q        <= asm_d;
            byte_idx_q   <= byte_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            stage_q      <= stage_d;
            stage_full_q <= stage_full_d;
            pend_q       <= pend_d;
            line_done_q  <= line_done_d;
            line_len_q   <= line_len_d;
            len_error_q  <= len_error_d;
            overflow_q   <= overflow_d;
        end
    end

    assign m_if.m_valid = !fifo_empty;
    assign m_if.m_data  = fifo_rdata[WORD_W-1:0];
    assign m_if.m_last  = fifo_rdata[LAST_BIT];
    assign m_if.m_err   = fifo_rdata[ERR_BIT];
    assign line_done    = line_done_q;
    assign line_len     = line_len_q;
    assign len_error    = len_error_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_linescanner_line_packer.sv
// Bench for the line packer: queue-based reference model compared every cycle, plus
// hand-computed word sequences for the directed scenarios.
module tb_linescanner_line_packer;

    localparam int DEPTH = 4;
    localparam int LPIX  = 8;

    logic       pixel_clock = 1'b0;
    logic       n_reset;
    logic       enable;
    logic [7:0] pixel_data;
    logic       pixel_captured;
    logic       line_done;
    logic [15:0] line_len;
    logic       len_error;
    logic       overflow;
    logic       clr_status;

    linescanner_line_packer_if m_if ();

    linescanner_line_packer #(
        .FIFO_DEPTH  (DEPTH),
        .LINE_PIXELS (LPIX)
    ) dut (
        .pixel_clock    (pixel_clock),
        .n_reset        (n_reset),
        .enable         (enable),
        .pixel_data     (pixel_data),
        .pixel_captured (pixel_captured),
        .m_if           (m_if),
        .line_done      (line_done),
        .line_len       (line_len),
        .len_error      (len_error),
        .overflow       (overflow),
        .clr_status     (clr_status)
    );

    initial forever #5 pixel_clock = ~pixel_clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (after the most recent rising edge).
    int          md_mode;       // 0 idle, 1 in line, 2 dropping, 3 waiting to write
    logic [7:0]  md_bytes [$];  // pixels of the line not yet written to the FIFO
    logic [33:0] md_fifo  [$];
    logic [33:0] md_pend;
    int          md_cnt;
    bit          md_lv_prev;
    bit          md_ld, md_le, md_ov;
    logic [15:0] md_ll;

    logic [33:0] got [$];
    int          ld_cnt, le_cnt;
    bit          chk_en = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endfunction

    function automatic logic [31:0] pack_bytes();
        logic [31:0] w = '0;
        foreach (md_bytes[i]) w[8*i +: 8] = md_bytes[i];
        return w;
    endfunction

    task automatic model_reset();
        md_bytes.delete();
        md_fifo.delete();
        md_mode = 0; md_pend = '0; md_cnt = 0; md_lv_prev = 1'b1;
        md_ld = 0; md_le = 0; md_ov = 0; md_ll = '0;
    endtask

    task automatic model_step();
        bit pop, full, rise, fin, evt, push;
        logic [33:0] ent;
        if (!n_reset) begin
            model_reset();
            return;
        end
        pop  = (md_fifo.size() > 0) && m_if.m_ready;
        full = (md_fifo.size() == DEPTH) && !pop;
        rise = pixel_captured && !md_lv_prev;
        fin = 0; evt = 0; push = 0; ent = '0;
        case (md_mode)
            0: if (rise && enable) begin
                md_mode = 1;
                md_bytes.delete();
                md_bytes.push_back(pixel_data);
                md_cnt = 1;
            end
            1: if (pixel_captured) begin
                if (md_cnt < 65535) md_cnt++;
                if (md_bytes.size() == 4) begin
                    if (full) begin
                        evt = 1; md_bytes.delete(); md_mode = 2;
                    end else begin
                        ent = {2'b00, pack_bytes()}; push = 1;
                        md_bytes.delete(); md_bytes.push_back(pixel_data);
                    end
                end else begin
                    md_bytes.push_back(pixel_data);
                end
            end else begin
                ent = {2'b01, pack_bytes()};
                md_bytes.delete();
                if (full) begin md_pend = ent; md_mode = 3; end
                else begin push = 1; fin = 1; end
            end
            2: if (pixel_captured) begin
                if (md_cnt < 65535) md_cnt++;
                evt = 1;
            end else begin
                md_pend = {2'b11, 32'h0}; md_mode = 3;
            end
            default: begin
                if (pixel_captured) evt = 1;
                if (!full) begin ent = md_pend; push = 1; fin = 1; end
            end
        endcase
        if (pop) void'(md_fifo.pop_front());
        if (push) md_fifo.push_back(ent);
        md_ld = fin;
        md_le = fin && (md_cnt != LPIX);
        if (fin) begin md_ll = 16'(md_cnt); md_mode = 0; end
        md_ov = (md_ov && !clr_status) || evt;
        md_lv_prev = pixel_captured;
    endtask

    always @(negedge pixel_clock) begin
        if (chk_en) begin
            chk("m_valid", m_if.m_valid, md_fifo.size() > 0);
            if (md_fifo.size() > 0)
                chk("m_entry", {m_if.m_err, m_if.m_last, m_if.m_data}, md_fifo[0]);
            chk("line_done", line_done, md_ld);
            chk("line_len", line_len, md_ll);
            chk("len_error", len_error, md_le);
            chk("overflow", overflow, md_ov);
            if (m_if.m_valid && m_if.m_ready) got.push_back({m_if.m_err, m_if.m_last, m_if.m_data});
            if (line_done) ld_cnt++;
            if (len_error) le_cnt++;
        end
    end

    task automatic drive(input bit en, input bit lv, input logic [7:0] d, input bit rdy,
                         input bit clr);
        enable = en; pixel_captured = lv; pixel_data = d;
        m_if.m_ready = rdy; clr_status = clr;
        @(posedge pixel_clock);
        #1;
        model_step();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic line(input int n, input logic [7:0] base, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, base + 8'(i), rdy, 1'b0);
    endtask

    task automatic check_got(input string name, input logic [33:0] exp [$]);
        chk({name, "_count"}, got.size(), exp.size());
        foreach (exp[i]) chk(name, (i < got.size()) ? got[i] : 34'h3_ffffffff, exp[i]);
    endtask

    initial begin
        logic [33:0] e [$];
        n_reset = 1'b0; enable = 1'b0; pixel_data = '0; pixel_captured = 1'b0;
        m_if.m_ready = 1'b0; clr_status = 1'b0;
        model_reset();
        chk_en = 1'b1;
        idle(3, 1'b1);
        chk("reset_outputs", {m_if.m_valid, m_if.m_data, line_len, overflow}, '0);
        n_reset = 1'b1;
        idle(2, 1'b1);

        // Full-length line.
        got.delete(); ld_cnt = 0; le_cnt = 0;
        line(8, 8'h01, 1'b1); idle(4, 1'b1);
        e = '{34'h0_04030201, 34'h1_08070605};
        check_got("full_line", e);
        chk("full_line_len", line_len, 16'd8);
        chk("full_line_done", ld_cnt, 1);
        chk("full_line_lenerr", le_cnt, 0);

        // Short line with partial final word.
        got.delete(); ld_cnt = 0; le_cnt = 0;
        line(6, 8'h11, 1'b1); idle(4, 1'b1);
        e = '{34'h0_14131211, 34'h1_00001615};
        check_got("short_line", e);
        chk("short_line_len", line_len, 16'd6);
        chk("short_line_lenerr", le_cnt, 1);

        // Overflow with a stalled consumer.
        got.delete();
        line(24, 8'h20, 1'b0); idle(4, 1'b0); idle(8, 1'b1);
        e = '{34'h0_23222120, 34'h0_27262524, 34'h0_2b2a2928, 34'h0_2f2e2d2c, 34'h3_00000000};
        check_got("overflow_line", e);
        chk("overflow_line_len", line_len, 16'd24);
        chk("overflow_flag", overflow, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1); idle(1, 1'b1);
        chk("overflow_cleared", overflow, 1'b0);

        // Back-to-back lines separated by one low cycle.
        got.delete();
        line(4, 8'h31, 1'b1); idle(1, 1'b1); line(4, 8'h41, 1'b1); idle(4, 1'b1);
        e = '{34'h1_34333231, 34'h1_44434241};
        check_got("back_to_back", e);

        // Reset mid-line, release with lval still high.
        got.delete();
        line(3, 8'h01, 1'b1);
        n_reset = 1'b0;
        #1;
        chk("async_reset", {m_if.m_valid, m_if.m_last, m_if.m_err, m_if.m_data, line_done,
                            len_error, overflow, line_len}, '0);
        model_reset();
        line(2, 8'h04, 1'b1);
        n_reset = 1'b1;
        line(3, 8'h06, 1'b1);
        chk("held_lval_ignored", got.size(), 0);
        idle(1, 1'b1); line(4, 8'h51, 1'b1); idle(4, 1'b1);
        e = '{34'h1_54535251};
        check_got("after_reset", e);

        // Enable low at line start, then dropped mid-line.
        got.delete();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);
        idle(2, 1'b1);
        chk("disabled_line", got.size(), 0);
        for (int i = 0; i < 8; i++) drive(i < 2, 1'b1, 8'h61 + 8'(i), 1'b1, 1'b0);
        idle(4, 1'b1);
        e = '{34'h0_64636261, 34'h1_68676665};
        check_got("enable_drop", e);

        // Randomised lines, gaps, back-pressure and status clears.
        for (int l = 0; l < 220; l++) begin
            int len, gap, rmode;
            len = $urandom_range(1, 20);
            gap = $urandom_range(1, 5);
            rmode = $urandom_range(0, 2);
            for (int c = 0; c < len + gap; c++) begin
                bit rdy;
                rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 9) < 7)
                                                         : ($urandom_range(0, 9) < 2);
                drive($urandom_range(0, 7) != 0, c < len, 8'($urandom), rdy,
                      $urandom_range(0, 31) == 0);
            end
        end
        idle(12, 1'b1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/linescanner_line_packer.md
Name: linescanner_line_packer

Overview:
- Downstream neighbour of the line-scanner capture unit. Consumes the `pixel_data` and `pixel_captured` (lval) stream on `pixel_clock`.
- Packs 8-bit pixels into 32-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready stream with end-of-line and error marking.
- Measures each line's length against the expected value and reports status to the control logic.

Parameters:
- FIFO_DEPTH, 16, number of 34-bit entries in the output FIFO; power of two, minimum 4.
- LINE_PIXELS, 1024, expected pixels per line, used for the length check (1..65535).

Ports:
- pixel_clock  in  1  sole clock; all logic on its rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, new lines are not accepted; a line already in progress completes.
- pixel_data  in  8  pixel value from the capture unit.
- pixel_captured  in  1  lval; high for each valid pixel of the current line.
- m_data  out  32  packed word; byte 0 is the earliest pixel.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the word when m_valid && m_ready.
- m_last  out  1  word is the final word of a line.
- m_err  out  1  word terminates a line whose data was truncated by overflow.
- line_done  out  1  one-cycle pulse when a line's final entry is written to the FIFO.
- line_len  out  16  pixel count of the most recent line, updated with line_done.
- len_error  out  1  one-cycle pulse with line_done when line_len != LINE_PIXELS.
- overflow  out  1  sticky flag; set when any pixel is discarded.
- clr_status  in  1  synchronous clear of overflow.

Behaviour:
Reset (n_reset=0, asynchronous):
- FIFO empty; state IDLE; all counters 0.
- All outputs 0: m_valid, m_last, m_err, line_done, len_error, overflow, line_len, m_data.
- After reset release, a line starts only on an observed 0->1 transition of pixel_captured. A line already high at release is ignored until lval goes low.

State machine:
- IDLE: on an lval rising edge with enable=1, go to ACTIVE. That first pixel is captured in the same cycle, with pix_cnt=1 and byte_idx=1.
- ACTIVE, each cycle with lval=1:
  - Write the byte into lane byte_idx of the assembly register.
  - byte_idx increments modulo 4; pix_cnt increments and saturates at 65535.
  - When lane 3 is written, the word moves to the staging register (stage_full=1).
  - Staging is pushed to the FIFO with last=0 on the next pixel cycle. This one-cycle hold lets the final word carry last.
  - If stage_full=1 and the FIFO is full when a push is needed: set overflow, discard the staged word and the current pixel, go to DROP.
- ACTIVE, lval falls:
  - If stage_full=1, push the staged word with last=1.
  - Else if byte_idx!=0, push the assembly word with last=1; unused upper lanes are 0.
  - If the FIFO is full, go to FLUSH and hold the word until space is available.
  - On the write, pulse line_done, register line_len, pulse len_error if line_len mismatches, return to IDLE.
- DROP:
  - Pixels are discarded and pix_cnt keeps counting.
  - On lval falling, go to FLUSH with the terminator entry {data=0, last=1, err=1}.
- FLUSH:
  - Write the pending entry as soon as the FIFO is not full, then do the line_done processing and go to IDLE.
  - If lval rises while in FLUSH, the whole new line is discarded, overflow is set, and no entry is produced for it.

FIFO:
- Entry layout {err, last, data[31:0]}.
- First-word fall-through: m_data, m_last and m_err are valid whenever m_valid=1.
- Simultaneous push and pop when full is allowed, and the push succeeds. "Full" for push decisions means count==FIFO_DEPTH && !(m_valid && m_ready).
- Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits.

Latency and status:
- A word completed by its 4th pixel appears on m_valid 2 cycles after that pixel, on the next pixel cycle or on lval fall.
- clr_status and a new overflow event in the same cycle: overflow remains 1.
- A zero-length line is impossible, because lval high for one cycle gives pix_cnt=1.

Decomposition:
- Package `linescanner_pkg`:
  - PIXEL_W=8, WORD_W=32
  - state encoding IDLE/ACTIVE/DROP/FLUSH
  - FIFO entry field offsets (ERR_BIT=33, LAST_BIT=32)
- Sub-module `linescanner_sync_fifo`: parameterised width/depth, first-word fall-through, full/empty, simultaneous read/write, asynchronous active-low reset.

Test Plan:
- LINE_PIXELS=8, m_ready=1, lval high 8 cycles with data 0x01..0x08 -> words 0x04030201 (m_last=0) and 0x08070605 (m_last=1); line_done pulse; line_len=8; len_error=0.
- LINE_PIXELS=8, 6-pixel line 0x11..0x16 -> words 0x14131211 and 0x00001615 (m_last=1); line_len=6; len_error pulse.
- FIFO_DEPTH=4, m_ready=0, 24-pixel line -> 4 words held (m_last=0); overflow=1. After raising m_ready: terminator {0, last=1, err=1} follows the 4 words; line_len=24.
- Back-to-back lines: 4-pixel line, lval low 1 cycle, then 4-pixel line -> two single-word entries, each m_last=1, with no merge across lines.
- Assert n_reset low mid-line after 3 pixels -> all outputs 0 immediately. lval still high at release -> no words until lval low then high.
- enable=0 at lval rise -> line ignored with no entries. enable dropped mid-line -> current line completes normally.
